// File: rtl/core_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer_pkg
// Description : Shared definitions for the multi-cycle core sequencer.
//               Contains RV32I opcodes, the EBREAK/ECALL encodings, the
//               sequencer state encoding, the trap cause codes and the
//               instruction-class enum produced by the opcode classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package core_sequencer_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Full-word SYSTEM encodings the sequencer recognises
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;

    // Sequencer states; the encoding is visible on the debug state port
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6,
        ST_TRAP    = 3'd7
    } state_e;

    // Trap cause codes
    localparam logic [1:0] CAUSE_NONE        = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL     = 2'd1;
    localparam logic [1:0] CAUSE_ECALL       = 2'd2;
    localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'd3;

    // Instruction classes as seen by the control path
    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,  // OP, OP_IMM, LUI, AUIPC
        CLS_JUMP   = 3'd1,  // JAL, JALR
        CLS_BRANCH = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_FENCE  = 3'd5,
        CLS_EBREAK = 3'd6,
        CLS_ECALL  = 3'd7
    } instr_class_e;

endpackage
`default_nettype wire

// File: rtl/core_sequencer_opcode_classifier.sv
`default_nettype none
// ============================================================================
// Module      : opcode_classifier
// Description : Combinational RV32I opcode classifier.
//   instr       in  32  instruction word
//   instr_class out  3  instruction class (CLS_*), CLS_ALU when illegal
//   illegal     out  1  unknown opcode or unsupported SYSTEM instruction
// Revision    : 1.0 - initial release
// ============================================================================
module opcode_classifier
    import core_sequencer_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_e instr_class,
    output logic         illegal
);

    always_comb begin
        instr_class = CLS_ALU;
        illegal     = 1'b0;
        case (instr[6:0])
            OPC_LOAD:   instr_class = CLS_LOAD;
            OPC_STORE:  instr_class = CLS_STORE;
            OPC_BRANCH: instr_class = CLS_BRANCH;
            OPC_JAL:    instr_class = CLS_JUMP;
            OPC_JALR:   instr_class = CLS_JUMP;
            OPC_OP:     instr_class = CLS_ALU;
            OPC_OP_IMM: instr_class = CLS_ALU;
            OPC_LUI:    instr_class = CLS_ALU;
            OPC_AUIPC:  instr_class = CLS_ALU;
            OPC_FENCE:  instr_class = CLS_FENCE;
            OPC_SYSTEM: begin
                // Only the exact EBREAK/ECALL words are supported
                if (instr == INSTR_EBREAK) begin
                    instr_class = CLS_EBREAK;
                end else if (instr == INSTR_ECALL) begin
                    instr_class = CLS_ECALL;
                end else begin
                    illegal = 1'b1;
                end
            end
            default:    illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle control FSM for the non-pipelined core. Steps
//               each instruction through FETCH/DECODE/EXECUTE/MEM/WB and
//               retires one instruction per pass.
//   clk, rst (async, active-high)
//   start, resume            control requests (IDLE / HALT only)
//   instr, branch_taken      fetched word and branch comparison result
//   dmem_ack                 data-memory completion
//   fetch_en, pc_write_en, pc_sel, regfile_we, dmem_req, dmem_we  strobes
//   halted, trap, trap_cause, state, instret                       status
// Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 16
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            resume,
    input  logic [31:0]     instr,
    input  logic            branch_taken,
    input  logic            dmem_ack,
    output logic            fetch_en,
    output logic            pc_write_en,
    output logic            pc_sel,
    output logic            regfile_we,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            halted,
    output logic            trap,
    output logic [1:0]      trap_cause,
    output logic [2:0]      state,
    output logic [XLEN-1:0] instret
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    instr_class_e      cls_q, cls_d;
    logic [1:0]        trap_cause_q, trap_cause_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [XLEN-1:0]   instret_q, instret_d;

    instr_class_e      dec_class;
    logic              dec_illegal;
    logic              wait_expired;

    opcode_classifier u_classifier (
        .instr       (instr),
        .instr_class (dec_class),
        .illegal     (dec_illegal)
    );

    // wait_q counts completed MEM cycles, so the last permitted cycle is
    // the one where it equals MEM_TIMEOUT-1.
    assign wait_expired = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cls_q        <= CLS_ALU;
            trap_cause_q <= CAUSE_NONE;
            wait_q       <= '0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            trap_cause_q <= trap_cause_d;
            wait_q       <= wait_d;
            instret_q    <= instret_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        trap_cause_d = trap_cause_q;
        wait_d       = '0;
        instret_d    = instret_q;
        fetch_en     = 1'b0;
        pc_write_en  = 1'b0;
        pc_sel       = 1'b0;
        regfile_we   = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        halted       = 1'b0;
        trap         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                fetch_en = 1'b1;
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                // Latch the class so later states need not see instr
                cls_d = dec_class;
                if (dec_illegal) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_ILLEGAL;
                end else if (dec_class == CLS_EBREAK) begin
                    state_d = ST_HALT;
                end else if (dec_class == CLS_ECALL) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_ECALL;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                case (cls_q)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_BRANCH: begin
                        pc_write_en = 1'b1;
                        pc_sel      = branch_taken;
                        state_d     = ST_FETCH;
                    end
                    CLS_FENCE: begin
                        pc_write_en = 1'b1;
                        state_d     = ST_FETCH;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == CLS_STORE);
                // Ack is checked first so an ack in the timeout cycle wins
                if (dmem_ack) begin
                    if (cls_q == CLS_STORE) begin
                        pc_write_en = 1'b1;
                        state_d     = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_expired) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_MEM_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_WB: begin
                regfile_we  = 1'b1;
                pc_write_en = 1'b1;
                pc_sel      = (cls_q == CLS_JUMP);
                state_d     = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    // Step past the EBREAK without counting it as retired
                    pc_write_en = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (pc_write_en && (state_q != ST_HALT)) begin
            instret_d = instret_q + XLEN'(1);
        end
    end

    assign state      = state_q;
    assign trap_cause = trap_cause_q;
    assign instret    = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_sequencer
// Description : Directed self-checking testbench for core_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

    localparam logic [31:0] I_ADDI   = 32'h0010_0093;
    localparam logic [31:0] I_BEQ    = 32'h0000_0463;
    localparam logic [31:0] I_LW     = 32'h0000_2083;
    localparam logic [31:0] I_SW     = 32'h0011_2023;
    localparam logic [31:0] I_JAL    = 32'h0000_006F;
    localparam logic [31:0] I_FENCE  = 32'h0000_000F;
    localparam logic [31:0] I_EBREAK = 32'h0010_0073;
    localparam logic [31:0] I_ECALL  = 32'h0000_0073;
    localparam logic [31:0] I_BAD    = 32'hFFFF_FFFF;

    // {fetch_en, pc_write_en, pc_sel, regfile_we, dmem_req, dmem_we, halted, trap}
    localparam logic [7:0] S_NONE   = 8'b0000_0000;
    localparam logic [7:0] S_FETCH  = 8'b1000_0000;
    localparam logic [7:0] S_WB     = 8'b0101_0000;
    localparam logic [7:0] S_WBJ    = 8'b0111_0000;
    localparam logic [7:0] S_BRT    = 8'b0110_0000;
    localparam logic [7:0] S_RET0   = 8'b0100_0000;
    localparam logic [7:0] S_LDREQ  = 8'b0000_1000;
    localparam logic [7:0] S_STACK  = 8'b0100_1100;
    localparam logic [7:0] S_HALT   = 8'b0000_0010;
    localparam logic [7:0] S_RESUME = 8'b0100_0010;
    localparam logic [7:0] S_TRAP   = 8'b0000_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        branch_taken = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        fetch_en, pc_write_en, pc_sel, regfile_we;
    logic        dmem_req, dmem_we, halted, trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
    logic [31:0] instret;
    logic [7:0]  strobes;

    int checks = 0;
    int errors = 0;

    assign strobes = {fetch_en, pc_write_en, pc_sel, regfile_we,
                      dmem_req, dmem_we, halted, trap};

    core_sequencer #(.XLEN(32), .MEM_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .resume       (resume),
        .instr        (instr),
        .branch_taken (branch_taken),
        .dmem_ack     (dmem_ack),
        .fetch_en     (fetch_en),
        .pc_write_en  (pc_write_en),
        .pc_sel       (pc_sel),
        .regfile_we   (regfile_we),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .halted       (halted),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .state        (state),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; resume = 1'b0;
        dmem_ack = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
        checks++; if (strobes !== S_NONE || trap_cause !== 2'd0) begin errors++; $display("FAIL reset_outputs: strobes=%b cause=%0d expected %b cause 0", strobes, trap_cause, S_NONE); end
    endtask

    task automatic test_alu();
        start = 1'b1; instr = I_ADDI;
        tick(); start = 1'b0; #1;
        checks++; if (state !== 3'd1 || strobes !== S_FETCH) begin errors++; $display("FAIL alu_fetch: state=%0d strobes=%b expected 1 %b", state, strobes, S_FETCH); end
        tick(); #1;
        checks++; if (state !== 3'd2 || strobes !== S_NONE) begin errors++; $display("FAIL alu_decode: state=%0d strobes=%b expected 2 %b", state, strobes, S_NONE); end
        tick(); #1;
        checks++; if (state !== 3'd3 || strobes !== S_NONE) begin errors++; $display("FAIL alu_execute: state=%0d strobes=%b expected 3 %b", state, strobes, S_NONE); end
        tick(); #1;
        checks++; if (state !== 3'd5 || strobes !== S_WB) begin errors++; $display("FAIL alu_wb: state=%0d strobes=%b expected 5 %b", state, strobes, S_WB); end
        tick(); #1;
        checks++; if (state !== 3'd1 || instret !== 32'd1) begin errors++; $display("FAIL alu_retire: state=%0d instret=%0d expected 1 1", state, instret); end
    endtask

    // Starts in FETCH; instr changes after DECODE to exercise the latched class
    task automatic test_branch();
        instr = I_BEQ;
        tick(); #1;
        tick(); instr = I_BAD; branch_taken = 1'b1; #1;
        checks++; if (state !== 3'd3 || strobes !== S_BRT) begin errors++; $display("FAIL branch_execute: state=%0d strobes=%b expected 3 %b", state, strobes, S_BRT); end
        tick(); branch_taken = 1'b0; #1;
        checks++; if (state !== 3'd1 || instret !== 32'd2) begin errors++; $display("FAIL branch_retire: state=%0d instret=%0d expected 1 2", state, instret); end
    endtask

    task automatic test_load_wait();
        int req_cycles;
        req_cycles = 0;
        instr = I_LW;
        tick(); #1;
        tick(); #1;
        for (int i = 0; i < 3; i++) begin
            tick(); dmem_ack = (i == 2); #1;
            if (strobes === S_LDREQ && state === 3'd4) req_cycles++;
        end
        checks++; if (req_cycles !== 3) begin errors++; $display("FAIL load_req_cycles: got %0d expected 3", req_cycles); end
        tick(); dmem_ack = 1'b0; #1;
        checks++; if (state !== 3'd5 || strobes !== S_WB) begin errors++; $display("FAIL load_wb: state=%0d strobes=%b expected 5 %b", state, strobes, S_WB); end
        tick(); #1;
        checks++; if (instret !== 32'd3) begin errors++; $display("FAIL load_instret: got %0d expected 3", instret); end
    endtask

    task automatic test_store();
        instr = I_SW;
        tick(); #1;
        tick(); #1;
        tick(); dmem_ack = 1'b1; #1;
        checks++; if (state !== 3'd4 || strobes !== S_STACK) begin errors++; $display("FAIL store_mem: state=%0d strobes=%b expected 4 %b", state, strobes, S_STACK); end
        tick(); dmem_ack = 1'b0; #1;
        checks++; if (state !== 3'd1 || instret !== 32'd4) begin errors++; $display("FAIL store_retire: state=%0d instret=%0d expected 1 4", state, instret); end
    endtask

    task automatic test_jal_fence();
        instr = I_JAL;
        tick(); #1;
        tick(); #1;
        tick(); #1;
        checks++; if (state !== 3'd5 || strobes !== S_WBJ) begin errors++; $display("FAIL jal_wb: state=%0d strobes=%b expected 5 %b", state, strobes, S_WBJ); end
        tick(); instr = I_FENCE; #1;
        tick(); #1;
        tick(); branch_taken = 1'b1; #1;
        checks++; if (state !== 3'd3 || strobes !== S_RET0) begin errors++; $display("FAIL fence_execute: state=%0d strobes=%b expected 3 %b", state, strobes, S_RET0); end
        tick(); branch_taken = 1'b0; #1;
        checks++; if (state !== 3'd1 || instret !== 32'd6) begin errors++; $display("FAIL fence_retire: state=%0d instret=%0d expected 1 6", state, instret); end
    endtask

    task automatic test_ebreak_resume();
        instr = I_EBREAK;
        tick(); #1;
        tick(); #1;
        checks++; if (state !== 3'd6 || strobes !== S_HALT) begin errors++; $display("FAIL halt_enter: state=%0d strobes=%b expected 6 %b", state, strobes, S_HALT); end
        tick(); start = 1'b1; #1;
        tick(); start = 1'b0; resume = 1'b1; #1;
        checks++; if (state !== 3'd6 || strobes !== S_RESUME || instret !== 32'd6) begin errors++; $display("FAIL halt_resume: state=%0d strobes=%b instret=%0d expected 6 %b 6", state, strobes, instret, S_RESUME); end
        tick(); resume = 1'b0; #1;
        checks++; if (state !== 3'd1 || instret !== 32'd6) begin errors++; $display("FAIL resume_fetch: state=%0d instret=%0d expected 1 6", state, instret); end
    endtask

    task automatic test_ecall();
        instr = I_ECALL;
        tick(); #1;
        tick(); #1;
        checks++; if (state !== 3'd7 || strobes !== S_TRAP || trap_cause !== 2'd2) begin errors++; $display("FAIL ecall_trap: state=%0d strobes=%b cause=%0d expected 7 %b 2", state, strobes, trap_cause, S_TRAP); end
    endtask

    task automatic test_illegal();
        do_reset();
        start = 1'b1; instr = I_BAD;
        tick(); start = 1'b0; #1;
        tick(); #1;
        tick(); #1;
        checks++; if (state !== 3'd7 || trap_cause !== 2'd1) begin errors++; $display("FAIL illegal_trap: state=%0d cause=%0d expected 7 1", state, trap_cause); end
    endtask

    task automatic test_timeout();
        int req_cycles;
        req_cycles = 0;
        do_reset();
        start = 1'b1; instr = I_LW;
        tick(); start = 1'b0; #1;
        tick(); #1;
        tick(); #1;
        for (int i = 0; i < 16; i++) begin
            tick(); #1;
            if (dmem_req === 1'b1 && state === 3'd4) req_cycles++;
        end
        checks++; if (req_cycles !== 16) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 16", req_cycles); end
        tick(); #1;
        checks++; if (state !== 3'd7 || trap_cause !== 2'd3 || dmem_req !== 1'b0) begin errors++; $display("FAIL timeout_trap: state=%0d cause=%0d req=%b expected 7 3 0", state, trap_cause, dmem_req); end
        for (int i = 0; i < 100; i++) begin
            tick(); dmem_ack = i[0]; resume = i[1]; start = i[2]; #1;
        end
        dmem_ack = 1'b0; resume = 1'b0; start = 1'b0;
        checks++; if (state !== 3'd7 || trap_cause !== 2'd3 || strobes !== S_TRAP) begin errors++; $display("FAIL timeout_sticky: state=%0d cause=%0d strobes=%b expected 7 3 %b", state, trap_cause, strobes, S_TRAP); end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        start = 1'b1; instr = I_ADDI;
        tick(); start = 1'b0; #1;
        tick(); #1;
        tick(); #1;
        tick(); #1;
        tick(); instr = I_LW; #1;
        checks++; if (instret !== 32'd1) begin errors++; $display("FAIL midmem_pre_instret: got %0d expected 1", instret); end
        tick(); #1;
        tick(); #1;
        tick(); #1;
        tick(); #1;
        checks++; if (state !== 3'd4 || dmem_req !== 1'b1) begin errors++; $display("FAIL midmem_in_mem: state=%0d req=%b expected 4 1", state, dmem_req); end
        rst = 1'b1; #1;
        checks++; if (dmem_req !== 1'b0 || state !== 3'd0 || instret !== 32'd0) begin errors++; $display("FAIL midmem_reset: req=%b state=%0d instret=%0d expected 0 0 0", dmem_req, state, instret); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_load_wait();
        test_store();
        test_jal_fence();
        test_ebreak_resume();
        test_ecall();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
